// File: rtl/prescaled_updown_counter_pkg.sv
// rtl/prescaled_updown_counter_pkg.sv - shared direction/mode encodings and legacy display rate
package prescaled_updown_counter_pkg;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // prescale value that reproduces the original display counter step rate
   localparam int unsigned DISPLAY_PRESCALE = 401;

endpackage

// File: rtl/prescaled_updown_counter_prescale_tick.sv
// rtl/prescaled_updown_counter_prescale_tick.sv - runtime prescaler producing one step per P enabled clocks
module prescale_tick #(
   parameter int PRESCALE_W = 17
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  sync_clr,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  step
);

   logic [PRESCALE_W-1:0] cycle;
   logic [PRESCALE_W-1:0] period_m1;
   logic                  period_done;

   // prescale of 0 behaves as 1; >= lets a lowered prescale step on the next enabled clock
   assign period_m1   = (prescale == '0) ? '0 : prescale - PRESCALE_W'(1);
   assign period_done = (cycle >= period_m1);
   assign step        = en && !sync_clr && period_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle <= '0;
      end else if (sync_clr) begin
         cycle <= '0;
      end else if (en) begin
         cycle <= period_done ? '0 : cycle + PRESCALE_W'(1);
      end
   end

endmodule

// File: rtl/prescaled_updown_counter.sv
// rtl/prescaled_updown_counter.sv - prescaled up/down counter with wrap/saturate limit and status pulses
module prescaled_updown_counter
   import prescaled_updown_counter_pkg::*;
#(
   parameter int WIDTH      = 12,
   parameter int MAX_VAL    = 4095,
   parameter int PRESCALE_W = 17
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  clr,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_val,
   input  logic                  dir,
   input  logic                  sat_mode,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [WIDTH-1:0]      count_val,
   output logic                  tick,
   output logic                  tc,
   output logic                  at_limit
);

   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

   logic step;

   prescale_tick #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescale (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .sync_clr (clr | load),
      .prescale (prescale),
      .step     (step)
   );

   assign at_limit = (dir == DIR_UP) ? (count_val == MAX_W) : (count_val == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_val <= '0;
         tick      <= 1'b0;
         tc        <= 1'b0;
      end else begin
         tick <= 1'b0;
         tc   <= 1'b0;
         if (clr) begin
            count_val <= '0;
         end else if (load) begin
            count_val <= (load_val > MAX_W) ? MAX_W : load_val;
         end else if (step) begin
            tick <= 1'b1;
            if (dir == DIR_UP) begin
               // an out-of-range count is treated as sitting at the limit
               if (count_val >= MAX_W) begin
                  tc        <= 1'b1;
                  count_val <= (sat_mode == MODE_SAT) ? MAX_W : '0;
               end else begin
                  count_val <= count_val + WIDTH'(1);
               end
            end else begin
               if (count_val == '0) begin
                  tc        <= 1'b1;
                  count_val <= (sat_mode == MODE_SAT) ? '0 : MAX_W;
               end else begin
                  count_val <= count_val - WIDTH'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// tb/tb_prescaled_updown_counter.sv - self-checking bench with behavioural reference model
module tb_prescaled_updown_counter;

   localparam int WIDTH      = 12;
   localparam int MAX_VAL    = 999;
   localparam int PRESCALE_W = 8;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  en;
   logic                  clr;
   logic                  load;
   logic [WIDTH-1:0]      load_val;
   logic                  dir;
   logic                  sat_mode;
   logic [PRESCALE_W-1:0] prescale;
   logic [WIDTH-1:0]      count_val;
   logic                  tick;
   logic                  tc;
   logic                  at_limit;

   int n_checks = 0;
   int n_err    = 0;

   prescaled_updown_counter #(
      .WIDTH      (WIDTH),
      .MAX_VAL    (MAX_VAL),
      .PRESCALE_W (PRESCALE_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .clr       (clr),
      .load      (load),
      .load_val  (load_val),
      .dir       (dir),
      .sat_mode  (sat_mode),
      .prescale  (prescale),
      .count_val (count_val),
      .tick      (tick),
      .tc        (tc),
      .at_limit  (at_limit)
   );

   always #5 clk = ~clk;

   // reference: count of enabled clocks since the last step, and the value after each step
   int m_count;
   int m_elapsed;
   bit m_tick;
   bit m_tc;

   always @(posedge clk or posedge reset) begin
      int p;
      if (reset) begin
         m_count   = 0;
         m_elapsed = 0;
         m_tick    = 0;
         m_tc      = 0;
      end else begin
         m_tick = 0;
         m_tc   = 0;
         if (clr) begin
            m_count   = 0;
            m_elapsed = 0;
         end else if (load) begin
            m_count   = (int'(load_val) > MAX_VAL) ? MAX_VAL : int'(load_val);
            m_elapsed = 0;
         end else if (en) begin
            p = (prescale == 0) ? 1 : int'(prescale);
            m_elapsed = m_elapsed + 1;
            if (m_elapsed >= p) begin
               m_elapsed = 0;
               m_tick    = 1;
               if (dir) begin
                  if (m_count >= MAX_VAL) begin
                     m_tc    = 1;
                     m_count = sat_mode ? MAX_VAL : 0;
                  end else begin
                     m_count = m_count + 1;
                  end
               end else begin
                  if (m_count == 0) begin
                     m_tc    = 1;
                     m_count = sat_mode ? 0 : MAX_VAL;
                  end else begin
                     m_count = m_count - 1;
                  end
               end
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // per-cycle comparison against the model, away from the rising edge
   always @(negedge clk) begin
      check("model_count", int'(count_val), m_count);
      check("model_tick", int'(tick), int'(m_tick));
      check("model_tc", int'(tc), int'(m_tc));
      check("model_at_limit", int'(at_limit),
            int'(dir ? (m_count == MAX_VAL) : (m_count == 0)));
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic do_load(input int v);
      load_val = WIDTH'(v);
      load     = 1'b1;
      cycles(1);
      load     = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      en       = 1'b0;
      clr      = 1'b0;
      load     = 1'b0;
      load_val = '0;
      dir      = 1'b1;
      sat_mode = 1'b0;
      prescale = 8'd3;
      cycles(2);
      reset = 1'b0;
      check("reset_count", int'(count_val), 0);
      check("reset_tick", int'(tick), 0);
      check("reset_tc", int'(tc), 0);

      // prescale 3, counting up
      en = 1'b1;
      cycles(3);
      check("t1_first_step", int'(count_val), 1);
      check("t1_first_tick", int'(tick), 1);
      cycles(1);
      check("t1_tick_low", int'(tick), 0);
      cycles(5);
      check("t1_third_step", int'(count_val), 3);
      do_load(995);
      check("t1_load", int'(count_val), 995);
      check("t1_load_no_tick", int'(tick), 0);
      cycles(12);
      check("t1_at_999", int'(count_val), 999);
      cycles(3);
      check("t1_wrap", int'(count_val), 0);
      check("t1_wrap_tc", int'(tc), 1);

      // saturate at both ends
      sat_mode = 1'b1;
      do_load(999);
      check("t2_at_limit", int'(at_limit), 1);
      cycles(3);
      check("t2_sat_hold", int'(count_val), 999);
      check("t2_sat_tick", int'(tick), 1);
      check("t2_sat_tc", int'(tc), 1);
      dir = 1'b0;
      cycles(3);
      check("t2_down", int'(count_val), 998);
      check("t2_down_tc", int'(tc), 0);
      do_load(1);
      cycles(3);
      check("t2_down_zero", int'(count_val), 0);
      cycles(3);
      check("t2_sat_zero", int'(count_val), 0);
      check("t2_sat_zero_tc", int'(tc), 1);

      // prescale 0/1 and enable gating
      sat_mode = 1'b0;
      dir      = 1'b1;
      prescale = 8'd0;
      do_load(5);
      cycles(1);
      check("t3_p0_a", int'(count_val), 6);
      cycles(1);
      check("t3_p0_b", int'(count_val), 7);
      check("t3_p0_tick", int'(tick), 1);
      en = 1'b0;
      cycles(1);
      check("t3_en_off", int'(count_val), 7);
      en = 1'b1;
      prescale = 8'd1;
      cycles(1);
      check("t3_p1", int'(count_val), 8);

      // lowering prescale mid-period
      prescale = 8'd10;
      clr = 1'b1;
      cycles(1);
      clr = 1'b0;
      check("t4_clr", int'(count_val), 0);
      cycles(6);
      check("t4_no_step", int'(count_val), 0);
      prescale = 8'd4;
      cycles(1);
      check("t4_early_step", int'(count_val), 1);
      cycles(3);
      check("t4_mid", int'(count_val), 1);
      cycles(1);
      check("t4_period4", int'(count_val), 2);

      // clr beats load, clamp, wrap down
      load_val = WIDTH'(5);
      load = 1'b1;
      clr  = 1'b1;
      cycles(1);
      load = 1'b0;
      clr  = 1'b0;
      check("t5_clr_over_load", int'(count_val), 0);
      do_load(4000);
      check("t5_clamp", int'(count_val), 999);
      prescale = 8'd1;
      dir = 1'b0;
      do_load(0);
      cycles(1);
      check("t5_wrap_down", int'(count_val), 999);
      check("t5_wrap_down_tc", int'(tc), 1);

      // async reset mid-period
      dir = 1'b1;
      prescale = 8'd5;
      do_load(7);
      cycles(2);
      reset = 1'b1;
      #1;
      check("t6_async_count", int'(count_val), 0);
      check("t6_async_tick", int'(tick), 0);
      reset = 1'b0;
      cycles(4);
      check("t6_no_step_yet", int'(count_val), 0);
      cycles(1);
      check("t6_step_after_p", int'(count_val), 1);

      // randomized traffic checked every cycle by the model
      for (int i = 0; i < 3000; i++) begin
         reset    = ($urandom_range(0, 199) == 0);
         clr      = ($urandom_range(0, 59) == 0);
         load     = ($urandom_range(0, 24) == 0);
         en       = ($urandom_range(0, 3) != 0);
         dir      = ($urandom_range(0, 31) == 0) ? ~dir : dir;
         sat_mode = ($urandom_range(0, 63) == 0) ? ~sat_mode : sat_mode;
         if ($urandom_range(0, 39) == 0) prescale = PRESCALE_W'($urandom_range(0, 6));
         case ($urandom_range(0, 3))
            0: load_val = WIDTH'($urandom_range(0, 3));
            1: load_val = WIDTH'($urandom_range(MAX_VAL - 3, MAX_VAL));
            default: load_val = WIDTH'($urandom_range(0, 4095));
         endcase
         cycles(1);
      end
      reset = 1'b0;
      clr   = 1'b0;
      load  = 1'b0;
      cycles(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
